// File: rtl/csa_pkg.sv
// Purpose: shared constants and elaboration helpers for the carry-select adder.
// Latency: not applicable (package only).
// Backpressure: not applicable (package only).
package csa_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SEG   = 8;
  localparam int DEF_SPS   = 2;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Pipeline depth: ceil(N / sps) with N = w / s. Degenerate parameters
  // collapse to one stage so elaboration reaches the explicit checks.
  function automatic int lat_of(input int w, input int s, input int sps);
    int n;
    if (s < 1 || sps < 1) return 1;
    n = w / s;
    if (n < 1) return 1;
    return (n + sps - 1) / sps;
  endfunction

endpackage

// File: rtl/csa_segment.sv
// Purpose: one carry-select segment; both candidate sums are formed up front
// Latency: combinational
// Backpressure: none (pure datapath slice)
// Ports: a_seg/b_seg segment operands, cin selects the candidate,
//        sum_seg/cout are the selected segment sum and carry out.
module csa_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           cin,
  output logic [SEG-1:0] sum_seg,
  output logic           cout
);

  logic [SEG:0] w_sum0;
  logic [SEG:0] w_sum1;

  // Candidate for carry-in 0 and carry-in 1; the real carry only drives the mux.
  assign w_sum0 = {1'b0, a_seg} + {1'b0, b_seg};
  assign w_sum1 = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, 1'b1};

  assign sum_seg = cin ? w_sum1[SEG-1:0] : w_sum0[SEG-1:0];
  assign cout    = cin ? w_sum1[SEG]     : w_sum0[SEG];

endmodule

// File: rtl/csa_pipe_adder.sv
// Purpose: pipelined carry-select adder/subtractor with signed-overflow flag
// Latency: LAT = ceil((WIDTH/SEG)/SEGS_PER_STAGE) cycles from accept to out_valid
// Backpressure: whole pipe freezes while out_valid && !out_ready; in_ready = !stall
// Ports: clk/rst (sync, active-high); in_valid/in_ready with a, b, c_in, sub;
//        out_valid/out_ready with sum, c_out (1 = no borrow on sub), ovf.
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int SEG            = DEF_SEG,
  parameter int SEGS_PER_STAGE = DEF_SPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  if (SEG < 1) begin : g_chk_seg
    $error("csa_pipe_adder: SEG must be at least 1");
  end else if (WIDTH % SEG != 0) begin : g_chk_width
    $error("csa_pipe_adder: WIDTH must be a multiple of SEG");
  end
  if (SEGS_PER_STAGE < 1) begin : g_chk_sps
    $error("csa_pipe_adder: SEGS_PER_STAGE must be at least 1");
  end

  // Clamped copies keep the arithmetic below defined while the checks fire.
  localparam int SEG_W = (SEG < 1) ? 1 : SEG;
  localparam int SPS_W = (SEGS_PER_STAGE < 1) ? 1 : SEGS_PER_STAGE;
  localparam int N     = WIDTH / SEG_W;
  localparam int LAT   = lat_of(WIDTH, SEG_W, SPS_W);

  // Stage registers
  logic [LAT-1:0]            r_vld;
  logic [LAT-1:0]            r_c;
  logic [LAT-1:0]            r_as;
  logic [LAT-1:0]            r_bs;
  logic [LAT-1:0][WIDTH-1:0] r_a;
  logic [LAT-1:0][WIDTH-1:0] r_b;
  logic [LAT-1:0][WIDTH-1:0] r_sum;

  // What each stage sees at its input, and what it hands to its register
  logic [LAT-1:0]            w_src_vld;
  logic [LAT-1:0]            w_src_c;
  logic [LAT-1:0]            w_src_as;
  logic [LAT-1:0]            w_src_bs;
  logic [LAT-1:0][WIDTH-1:0] w_src_a;
  logic [LAT-1:0][WIDTH-1:0] w_src_b;
  logic [LAT-1:0][WIDTH-1:0] w_src_sum;
  logic [LAT-1:0][WIDTH-1:0] w_nxt_sum;
  logic [LAT-1:0]            w_nxt_c;
  logic [WIDTH-1:0]          w_res_all;

  logic [WIDTH-1:0] w_bb;
  logic             w_cc;
  logic             w_stall;
  logic             w_unused;

  assign w_bb    = sub ? ~b : b;
  assign w_cc    = sub ? 1'b1 : c_in;
  assign w_stall = r_vld[LAT-1] && !out_ready;
  // Reset forces the pipe empty, so accepting is always safe during reset.
  assign in_ready = rst || !w_stall;

  for (genvar s = 0; s < LAT; s++) begin : g_src
    if (s == 0) begin : g_head
      assign w_src_vld[s] = in_valid;
      assign w_src_c[s]   = w_cc;
      assign w_src_as[s]  = a[WIDTH-1];
      assign w_src_bs[s]  = w_bb[WIDTH-1];
      assign w_src_a[s]   = a;
      assign w_src_b[s]   = w_bb;
      assign w_src_sum[s] = '0;
    end else begin : g_body
      assign w_src_vld[s] = r_vld[s-1];
      assign w_src_c[s]   = r_c[s-1];
      assign w_src_as[s]  = r_as[s-1];
      assign w_src_bs[s]  = r_bs[s-1];
      assign w_src_a[s]   = r_a[s-1];
      assign w_src_b[s]   = r_b[s-1];
      assign w_src_sum[s] = r_sum[s-1];
    end
  end

  // Segment i belongs to stage i/SPS; the first segment of a stage takes the
  // registered running carry, the others chain within the stage.
  for (genvar i = 0; i < N; i++) begin : g_seg
    localparam int S = i / SPS_W;
    logic             w_cin;
    logic             w_cout;
    logic [SEG_W-1:0] w_sum;

    if (i % SPS_W == 0) begin : g_first
      assign w_cin = w_src_c[S];
    end else begin : g_chain
      assign w_cin = g_seg[i-1].w_cout;
    end

    csa_segment #(.SEG(SEG_W)) u_seg (
      .a_seg   (w_src_a[S][i*SEG_W +: SEG_W]),
      .b_seg   (w_src_b[S][i*SEG_W +: SEG_W]),
      .cin     (w_cin),
      .sum_seg (w_sum),
      .cout    (w_cout)
    );

    assign w_res_all[i*SEG_W +: SEG_W] = w_sum;
  end

  // Each stage overlays its own resolved bit range onto the partial sum;
  // the last stage may cover fewer segments than SPS.
  for (genvar s = 0; s < LAT; s++) begin : g_stage
    localparam int LO     = s * SPS_W * SEG_W;
    localparam int HI_SEG = ((s + 1) * SPS_W < N) ? (s + 1) * SPS_W : N;
    localparam int HI     = HI_SEG * SEG_W;
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] M_HI = (HI >= WIDTH) ? ONES : ~(ONES << HI);
    localparam logic [WIDTH-1:0] MASK = M_HI & (ONES << LO);

    assign w_nxt_sum[s] = (w_src_sum[s] & ~MASK) | (w_res_all & MASK);
    assign w_nxt_c[s]   = g_seg[HI_SEG-1].w_cout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_c   <= '0;
      r_as  <= '0;
      r_bs  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_sum <= '0;
    end else if (!w_stall) begin
      r_vld <= w_src_vld;
      r_c   <= w_nxt_c;
      r_as  <= w_src_as;
      r_bs  <= w_src_bs;
      r_a   <= w_src_a;
      r_b   <= w_src_b;
      r_sum <= w_nxt_sum;
    end
  end

  // Operand bits already consumed (and the whole last-stage copy) go nowhere.
  assign w_unused = ^{r_a, r_b};

  assign out_valid = r_vld[LAT-1];
  assign sum       = r_sum[LAT-1];
  assign c_out     = r_c[LAT-1];
  assign ovf       = (r_as[LAT-1] == r_bs[LAT-1]) && (r_sum[LAT-1][WIDTH-1] != r_as[LAT-1]);

endmodule

// File: tb/tb_csa_pipe_adder.sv
module tb_csa_pipe_adder;

  localparam int LAT0 = 4;
  localparam int LAT1 = 3;

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ov;
    int          cyc;   // expected arrival cycle, or -1 when not checked
  } exp_t;

  logic clk;
  logic rst;

  logic        in_valid0, in_ready0, c_in0, sub0, out_valid0, out_ready0, c_out0, ovf0;
  logic [63:0] a0, b0, sum0;
  logic        in_valid1, in_ready1, c_in1, sub1, out_valid1, out_ready1, c_out1, ovf1;
  logic [31:0] a1, b1, sum1;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   rnd_mode = 0;
  exp_t q0[$];
  exp_t q1[$];

  csa_pipe_adder u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .c_in(c_in0), .sub(sub0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .sum(sum0), .c_out(c_out0), .ovf(ovf0)
  );

  csa_pipe_adder #(.WIDTH(32), .SEG(4), .SEGS_PER_STAGE(3)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .c_in(c_in1), .sub(sub1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .c_out(c_out1), .ovf(ovf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] s, input logic co, input logic ov, input int cyc_chk);
    exp_t e;
    e.s = s; e.co = co; e.ov = ov; e.cyc = cyc_chk;
    return e;
  endfunction

  // Two's-complement reference for the random streams.
  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic ci, input logic sb);
    logic [63:0] yy;
    logic [64:0] r;
    yy = sb ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {64'd0, (sb ? 1'b1 : ci)};
    return mk(r[63:0], r[64], (x[63] == yy[63]) && (r[63] != x[63]), -1);
  endfunction

  // Presents one operation and pushes its expectation once the DUT accepts it.
  // e.cyc >= 0 requests a latency check against the acceptance cycle.
  task automatic send(input int d, input logic [63:0] ta, input logic [63:0] tb,
                      input logic tci, input logic tsb, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    if (d == 0) begin
      a0 = ta; b0 = tb; c_in0 = tci; sub0 = tsb; in_valid0 = 1'b1; in_valid1 = 1'b0;
    end else begin
      a1 = ta[31:0]; b1 = tb[31:0]; c_in1 = tci; sub1 = tsb; in_valid1 = 1'b1; in_valid0 = 1'b0;
    end
    #1;
    while (!(d == 0 ? in_ready0 : in_ready1)) begin
      n++;
      if (n > 500) begin
        total++; bad++;
        $display("FAIL accept_timeout dut%0d: in_ready stayed 0 for %0d cycles, required 1", d, n);
        return;
      end
      @(negedge clk); #1;
    end
    if (e.cyc >= 0) e.cyc = cyc + (d == 0 ? LAT0 : LAT1);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle(0);
    while (q0.size() != 0 || q1.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        total++; bad++;
        $display("FAIL drain_timeout: %0d/%0d results outstanding, required 0", q0.size(), q1.size());
        q0.delete(); q1.delete();
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // Consumer side of the wide DUT.
  initial begin
    out_ready0 = 1'b1;
    out_ready1 = 1'b1;
    forever begin
      @(negedge clk);
      out_ready0 = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor for the wide DUT: checks hold-while-stalled and pops on transfer.
  initial begin
    bit          held;
    logic [63:0] h_sum;
    logic        h_co, h_ov;
    exp_t        e;
    held = 0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        held = 0;
      end else begin
        if (held) begin
          chk("d0 hold_valid", {63'd0, out_valid0}, 64'd1);
          chk("d0 hold_sum", sum0, h_sum);
          chk("d0 hold_cout", {63'd0, c_out0}, {63'd0, h_co});
          chk("d0 hold_ovf", {63'd0, ovf0}, {63'd0, h_ov});
        end
        held = 0;
        if (out_valid0) begin
          if (out_ready0) begin
            if (q0.size() == 0) begin
              total++; bad++;
              $display("FAIL d0 unexpected: got result %0h with nothing outstanding", sum0);
            end else begin
              e = q0.pop_front();
              chk("d0 sum", sum0, e.s);
              chk("d0 cout", {63'd0, c_out0}, {63'd0, e.co});
              chk("d0 ovf", {63'd0, ovf0}, {63'd0, e.ov});
              if (e.cyc >= 0) chk("d0 latency", 64'(cyc), 64'(e.cyc));
            end
          end else begin
            held = 1; h_sum = sum0; h_co = c_out0; h_ov = ovf0;
          end
        end
      end
    end
  end

  // Monitor for the narrow DUT (always ready).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst && out_valid1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL d1 unexpected: got result %0h with nothing outstanding", sum1);
        end else begin
          e = q1.pop_front();
          chk("d1 sum", {32'd0, sum1}, e.s);
          chk("d1 cout", {63'd0, c_out1}, {63'd0, e.co});
          chk("d1 ovf", {63'd0, ovf1}, {63'd0, e.ov});
          if (e.cyc >= 0) chk("d1 latency", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    logic [63:0] ra, rb;
    logic        rc, rs;
    rst = 1'b1;
    in_valid0 = 0; a0 = '0; b0 = '0; c_in0 = 0; sub0 = 0;
    in_valid1 = 0; a1 = '0; b1 = '0; c_in1 = 0; sub1 = 0;
    repeat (3) @(negedge clk);
    #3;
    chk("in_ready_in_reset", {63'd0, in_ready0}, 64'd1);
    rst = 1'b0;
    @(negedge clk); #3;
    chk("rst out_valid", {63'd0, out_valid0}, 64'd0);
    chk("rst sum", sum0, 64'd0);
    chk("rst cout", {63'd0, c_out0}, 64'd0);
    chk("rst ovf", {63'd0, ovf0}, 64'd0);
    chk("rst in_ready", {63'd0, in_ready0}, 64'd1);
    chk("rst d1 out_valid", {63'd0, out_valid1}, 64'd0);

    // Directed vectors, back to back, each at exact latency
    send(0, 64'd3, 64'd5, 1'b0, 1'b0, mk(64'd8, 0, 0, 0));
    send(0, 64'd3, 64'd5, 1'b1, 1'b0, mk(64'd9, 0, 0, 0));
    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
         mk(64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0));
    send(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, mk(64'h8000_0000_0000_0000, 0, 1, 0));
    send(0, 64'hA, 64'hB, 1'b0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0));
    send(0, 64'hB, 64'hA, 1'b1, 1'b1, mk(64'd1, 1, 0, 0));
    send(0, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, mk(64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0));
    send(0, 64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001, 1'b0, 1'b0,
         mk(64'h0100_0100_0100_0100, 0, 0, 0));
    drain();

    // Random stream with a wobbling consumer
    rnd_mode = 1;
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      send(0, ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    drain();
    rnd_mode = 0;
    repeat (2) @(negedge clk);

    // Random stream at full throughput: every result exactly LAT after issue
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      send(0, ra, rb, rc, rs, mk(model(ra, rb, rc, rs).s, model(ra, rb, rc, rs).co,
                                 model(ra, rb, rc, rs).ov, 0));
    end
    drain();

    // Reset with three operations in flight
    send(0, 64'd100, 64'd1, 1'b0, 1'b0, mk(64'd101, 0, 0, 0));
    send(0, 64'd200, 64'd2, 1'b0, 1'b0, mk(64'd202, 0, 0, 0));
    send(0, 64'd300, 64'd3, 1'b0, 1'b0, mk(64'd303, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1; in_valid0 = 1'b0;
    q0.delete();
    @(negedge clk); #3;
    chk("midrst out_valid", {63'd0, out_valid0}, 64'd0);
    chk("midrst in_ready", {63'd0, in_ready0}, 64'd1);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    send(0, 64'd3, 64'd5, 1'b0, 1'b0, mk(64'd8, 0, 0, 0));
    drain();

    // Narrow configuration with a partial last stage
    send(1, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0, mk(64'd0, 1, 0, 0));
    send(1, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, mk(64'h8000_0000, 0, 1, 0));
    send(1, 64'h0FFF_FFFF, 64'd1, 1'b0, 1'b0, mk(64'h1000_0000, 0, 0, 0));
    send(1, 64'd0, 64'd1, 1'b0, 1'b1, mk(64'hFFFF_FFFF, 0, 0, 0));
    send(1, 64'h0000_0FFF, 64'd1, 1'b1, 1'b0, mk(64'h0000_1001, 0, 0, 0));
    send(1, 64'hFFFF_FFFF, 64'd0, 1'b1, 1'b0, mk(64'd0, 1, 0, 0));
    send(1, 64'h00F0_0000, 64'h0010_0000, 1'b0, 1'b0, mk(64'h0100_0000, 0, 0, 0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
